// File: rtl/wb_slave_mem_if.sv
// Wishbone B4 classic bus bundle between a master and wb_slave_mem.
// Signal names follow the slave-side Wishbone naming (_I into the slave, _O out of it).
interface wb_slave_mem_if;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [63:0] ADR_I;
    logic [7:0]  SEL_I;
    logic [63:0] DAT_I;
    logic [15:0] TGD_I;
    logic [15:0] TGA_I;
    logic [15:0] TGC_I;
    logic        LOCK_I;
    logic [63:0] DAT_O;
    logic [15:0] TGD_O;
    logic        ACK_O;
    logic        ERR_O;
    logic        RTY_O;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I, TGD_I, TGA_I, TGC_I, LOCK_I,
        input  DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I, TGD_I, TGA_I, TGC_I, LOCK_I,
        output DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
    );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone B4 classic slave with a 64-bit word memory, address window decode and wait states.
// Optional WB_SLAVE_MEM_RETRY_EN adds a retry_req input that turns a response into RTY_O.
module wb_slave_mem #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic clk,
    input logic RST_I,
`ifdef WB_SLAVE_MEM_RETRY_EN
    input logic retry_req,
`endif
    wb_slave_mem_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_req;
    logic                 w_enter_resp;
    logic                 w_hit;
    logic                 w_retry;
    logic                 w_err;
    logic                 w_wr;
    logic [ADDR_BITS-1:0] w_idx;
    logic [63:0]          w_mask;
    logic                 w_unused;

    // Contents survive reset; zero start value gives defined reads of unwritten words.
    logic [63:0] r_mem [DEPTH] = '{default: '0};
    logic [15:0] r_tag [DEPTH] = '{default: '0};

    logic        r_ack;
    logic        r_err;
    logic        r_rty;
    logic [63:0] r_dat;
    logic [15:0] r_tgd;

`ifdef WB_SLAVE_MEM_RETRY_EN
    assign w_retry = retry_req;
`else
    assign w_retry = 1'b0;
`endif

    assign w_req    = bus.CYC_I && bus.STB_I;
    assign w_hit    = (bus.ADR_I[63:ADDR_BITS+3] == BASE_ADDR[63:ADDR_BITS+3]);
    assign w_idx    = bus.ADR_I[ADDR_BITS+2:3];
    assign w_err    = !w_hit || (bus.SEL_I == 8'h00);
    assign w_wr     = !w_retry && !w_err && bus.WE_I;
    assign w_unused = ^{bus.TGA_I, bus.TGC_I, bus.LOCK_I, bus.ADR_I[2:0]};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_mask[8*i +: 8] = {8{bus.SEL_I[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (RST_I) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A dropped CYC_I/STB_I in WAIT abandons the access without a response.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_cnt_nxt = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!w_req) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST_I && w_enter_resp && w_wr) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.SEL_I[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.DAT_I[8*i +: 8];
                end
            end
            r_tag[w_idx] <= bus.TGD_I;
        end
    end

    // Termination strobes and read data are live only in the RESP cycle.
    always_ff @(posedge clk) begin
        if (RST_I) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_rty <= 1'b0;
            r_dat <= '0;
            r_tgd <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_rty <= 1'b0;
            r_dat <= '0;
            r_tgd <= '0;
            if (w_enter_resp) begin
                if (w_retry) begin
                    r_rty <= 1'b1;
                end else if (w_err) begin
                    r_err <= 1'b1;
                end else begin
                    r_ack <= 1'b1;
                    if (!bus.WE_I) begin
                        r_dat <= r_mem[w_idx] & w_mask;
                        r_tgd <= r_tag[w_idx];
                    end
                end
            end
        end
    end

    assign bus.ACK_O = r_ack;
    assign bus.ERR_O = r_err;
    assign bus.RTY_O = r_rty;
    assign bus.DAT_O = r_dat;
    assign bus.TGD_O = r_tgd;
endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: one instance with 1 wait state, one with 3.
module tb_wb_slave_mem;
    localparam logic [63:0] BASE    = 64'h0000_0001_0000_0000;
    localparam logic [2:0]  T_ACK   = 3'b100;
    localparam logic [2:0]  T_ERR   = 3'b010;
    localparam logic [2:0]  T_RTY   = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef WB_SLAVE_MEM_RETRY_EN
    logic retry_req = 1'b0;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_slave_mem_if b1 ();
    wb_slave_mem_if b3 ();

    wb_slave_mem #(.ADDR_BITS(10), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut1 (
        .clk   (clk),
        .RST_I (rst),
`ifdef WB_SLAVE_MEM_RETRY_EN
        .retry_req (retry_req),
`endif
        .bus   (b1)
    );

    wb_slave_mem #(.ADDR_BITS(10), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
        .clk   (clk),
        .RST_I (rst),
`ifdef WB_SLAVE_MEM_RETRY_EN
        .retry_req (retry_req),
`endif
        .bus   (b3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive bus d (0 -> 1-wait instance, 1 -> 3-wait instance); the other bus idles.
    task automatic drive(input int d, input logic req, input logic we, input logic [63:0] adr,
                         input logic [7:0] sel, input logic [63:0] dat, input logic [15:0] tgd);
        b1.CYC_I = (d == 0) && req;  b1.STB_I = (d == 0) && req;
        b3.CYC_I = (d == 1) && req;  b3.STB_I = (d == 1) && req;
        b1.WE_I = we;  b1.ADR_I = adr;  b1.SEL_I = sel;  b1.DAT_I = dat;  b1.TGD_I = tgd;
        b3.WE_I = we;  b3.ADR_I = adr;  b3.SEL_I = sel;  b3.DAT_I = dat;  b3.TGD_I = tgd;
        b1.TGA_I = 16'h0;  b1.TGC_I = 16'h0;  b1.LOCK_I = 1'b0;
        b3.TGA_I = 16'h0;  b3.TGC_I = 16'h0;  b3.LOCK_I = 1'b0;
    endtask

    function automatic logic [2:0] term_of(input int d);
        return (d == 1) ? {b3.ACK_O, b3.ERR_O, b3.RTY_O} : {b1.ACK_O, b1.ERR_O, b1.RTY_O};
    endfunction

    function automatic logic [63:0] quiet(input int d);
        if (d == 1)
            return 64'((b3.ACK_O | b3.ERR_O | b3.RTY_O | (|b3.DAT_O) | (|b3.TGD_O)) == 1'b0);
        return 64'((b1.ACK_O | b1.ERR_O | b1.RTY_O | (|b1.DAT_O) | (|b1.TGD_O)) == 1'b0);
    endfunction

    task automatic access(input int d, input logic we, input logic [63:0] adr, input logic [7:0] sel,
                          input logic [63:0] dat, input logic [15:0] tgd,
                          output int lat, output logic [2:0] term,
                          output logic [63:0] rd, output logic [15:0] rtg);
        lat = 0; term = '0; rd = '0; rtg = '0;
        drive(d, 1'b1, we, adr, sel, dat, tgd);
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (term_of(d) != 3'b000) begin
                lat  = i;
                term = term_of(d);
                rd   = (d == 1) ? b3.DAT_O : b1.DAT_O;
                rtg  = (d == 1) ? b3.TGD_O : b1.TGD_O;
                break;
            end
        end
        drive(d, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 16'h0);
        tick;
    endtask

    initial begin
        int          lat;
        logic [2:0]  term;
        logic [63:0] rd;
        logic [15:0] rtg;
        logic        seen;

        drive(0, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 16'h0);
        rst = 1'b1;
        tick; tick;
        chk("reset_quiet_ws1", quiet(0), 64'd1);
        chk("reset_quiet_ws3", quiet(1), 64'd1);
        rst = 1'b0;
        tick; tick; tick;
        chk("idle_quiet", quiet(0), 64'd1);

        access(0, 1'b1, BASE + 64'h10, 8'hFF, 64'hDEAD_BEEF_0123_4567, 16'hA5A5, lat, term, rd, rtg);
        chk("wr_lat", 64'(lat), 64'd2);
        chk("wr_term", 64'(term), 64'(T_ACK));
        chk("wr_single_cycle", quiet(0), 64'd1);

        access(0, 1'b0, BASE + 64'h10, 8'h0F, 64'h0, 16'h0, lat, term, rd, rtg);
        chk("rd_lat", 64'(lat), 64'd2);
        chk("rd_term", 64'(term), 64'(T_ACK));
        chk("rd_data_sel0f", rd, 64'h0000_0000_0123_4567);
        chk("rd_tag", 64'(rtg), 64'hA5A5);
        chk("rd_single_cycle", quiet(0), 64'd1);

        access(0, 1'b1, BASE + 64'h10, 8'h80, 64'hFF00_0000_0000_0000, 16'h1234, lat, term, rd, rtg);
        chk("pwr_term", 64'(term), 64'(T_ACK));
        access(0, 1'b0, BASE + 64'h10, 8'h8F, 64'h0, 16'h0, lat, term, rd, rtg);
        chk("prd_data_sel8f", rd, 64'hFF00_0000_0123_4567);
        chk("prd_tag", 64'(rtg), 64'h1234);
        access(0, 1'b0, BASE + 64'h10, 8'hFF, 64'h0, 16'h0, lat, term, rd, rtg);
        chk("prd_data_full", rd, 64'hFFAD_BEEF_0123_4567);

        access(0, 1'b0, BASE + 64'h2000, 8'hFF, 64'h0, 16'h0, lat, term, rd, rtg);
        chk("miss_hi_term", 64'(term), 64'(T_ERR));
        chk("miss_hi_lat", 64'(lat), 64'd2);
        chk("miss_hi_data", rd, 64'h0);
        chk("miss_hi_single", quiet(0), 64'd1);
        access(0, 1'b0, 64'h10, 8'hFF, 64'h0, 16'h0, lat, term, rd, rtg);
        chk("miss_lo_term", 64'(term), 64'(T_ERR));
        access(0, 1'b1, BASE + 64'h10, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, lat, term, rd, rtg);
        chk("sel0_term", 64'(term), 64'(T_ERR));
        access(0, 1'b0, BASE + 64'h10, 8'hFF, 64'h0, 16'h0, lat, term, rd, rtg);
        chk("after_err_data", rd, 64'hFFAD_BEEF_0123_4567);
        chk("after_err_tag", 64'(rtg), 64'h1234);

        access(1, 1'b1, BASE + 64'h18, 8'hFF, 64'h0123_4567_89AB_CDEF, 16'h5A5A, lat, term, rd, rtg);
        chk("ws3_wr_lat", 64'(lat), 64'd4);
        chk("ws3_wr_term", 64'(term), 64'(T_ACK));

        drive(1, 1'b1, 1'b1, BASE + 64'h18, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF);
        tick;
        drive(1, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 16'h0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (term_of(1) != 3'b000) seen = 1'b1;
        end
        chk("abort_no_strobe", 64'(seen), 64'd0);

        drive(1, 1'b1, 1'b1, BASE + 64'h18, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF);
        tick; tick;
        rst = 1'b1;
        tick;
        chk("rst_wait_quiet", quiet(1), 64'd1);
        rst = 1'b0;
        drive(1, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 16'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (term_of(1) != 3'b000) seen = 1'b1;
        end
        chk("rst_wait_no_strobe", 64'(seen), 64'd0);

        access(1, 1'b0, BASE + 64'h18, 8'hFF, 64'h0, 16'h0, lat, term, rd, rtg);
        chk("ws3_rd_lat", 64'(lat), 64'd4);
        chk("ws3_rd_data", rd, 64'h0123_4567_89AB_CDEF);
        chk("ws3_rd_tag", 64'(rtg), 64'h5A5A);

`ifdef WB_SLAVE_MEM_RETRY_EN
        retry_req = 1'b1;
        access(0, 1'b1, BASE + 64'h20, 8'hFF, 64'h1111_2222_3333_4444, 16'hBEEF, lat, term, rd, rtg);
        chk("rty_term", 64'(term), 64'(T_RTY));
        chk("rty_data", rd, 64'h0);
        retry_req = 1'b0;
        access(0, 1'b0, BASE + 64'h20, 8'hFF, 64'h0, 16'h0, lat, term, rd, rtg);
        chk("rty_no_update", rd, 64'h0);
        access(0, 1'b1, BASE + 64'h20, 8'hFF, 64'h1111_2222_3333_4444, 16'hBEEF, lat, term, rd, rtg);
        chk("rty_again_term", 64'(term), 64'(T_ACK));
        access(0, 1'b0, BASE + 64'h20, 8'hFF, 64'h0, 16'h0, lat, term, rd, rtg);
        chk("rty_again_data", rd, 64'h1111_2222_3333_4444);
        chk("rty_again_tag", 64'(rtg), 64'hBEEF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_slave_mem.md
# wb_slave_mem

Wishbone B4 classic-cycle slave with a 64-bit word-addressed local memory; it is the responder for the testbench Wishbone master interface. It decodes a configurable address window, inserts a programmable number of wait states, and answers each access with exactly one ACK, ERR or (optionally) RTY pulse. It sits on the DUT side of the bench as a synthesizable memory target and as the reference responder for master-side sequences.

## Interface
- ADDR_BITS, 10: memory depth in 64-bit words (2^ADDR_BITS).
- BASE_ADDR, 64'h0: byte base of the decoded window; must be aligned to 8·2^ADDR_BITS.
- WAIT_STATES, 1: cycles inserted between request sample and response (0..15).
- clk  input  1  system clock; all logic on rising edge.
- RST_I  input  1  synchronous, active-high reset.
- CYC_I  input  1  bus cycle valid.
- STB_I  input  1  strobe; access requested when CYC_I&&STB_I.
- WE_I  input  1  1 = write, 0 = read.
- ADR_I  input  64  byte address; bits [2:0] ignored.
- SEL_I  input  8  byte lanes; bit i enables DAT bits [8i+7:8i].
- DAT_I  input  64  write data.
- TGD_I  input  16  write data tag; stored per word alongside data.
- TGA_I, TGC_I  input  16 each  address/cycle tags; accepted, no effect.
- LOCK_I  input  1  accepted, no effect.
- DAT_O  output  64  read data.
- TGD_O  output  16  read data tag.
- ACK_O, ERR_O, RTY_O  output  1 each  termination strobes.

## Operation
- FSM states IDLE, WAIT, RESP.
- IDLE: on an edge with CYC_I&&STB_I, load wait counter with WAIT_STATES; go WAIT if WAIT_STATES>0, else go RESP directly.
- WAIT: decrement counter each edge; at counter==1 go RESP. If CYC_I or STB_I is low at any WAIT edge, go IDLE: no response, no memory change.
- Transition into RESP (the edge that asserts the strobe) performs the access using ADR_I/WE_I/SEL_I/DAT_I/TGD_I present at that edge.
- Decode: hit when ADR_I[63:ADDR_BITS+3] == BASE_ADDR[63:ADDR_BITS+3]; word index = ADR_I[ADDR_BITS+2:3].
- ERR: miss, or SEL_I==0. ERR_O pulses, memory untouched, DAT_O/TGD_O = 0.
- Write hit: update only lanes with SEL_I set; TGD_I stored whole when any lane set; ACK_O pulses.
- Read hit: DAT_O = full stored word masked by SEL_I (unselected lanes 0), TGD_O = stored tag; ACK_O pulses.
- RESP: exactly one cycle, always returns to IDLE; IDLE never samples in the same edge that leaves RESP.
- Exactly one of ACK_O/ERR_O/RTY_O high in RESP; all low otherwise.
- Memory is not cleared by reset; unwritten words read as 0 in simulation (initialised to 0).

## Timing
- Reset values: ACK_O=0, ERR_O=0, RTY_O=0, DAT_O=0, TGD_O=0, state IDLE, counter 0.
- RST_I high at any edge, including mid-WAIT/RESP: next cycle IDLE, all outputs 0, pending access dropped, no write.
- Request sampled at edge k: strobe high in cycle after edge k+WAIT_STATES, low after edge k+WAIT_STATES+1.
- Throughput: one access per WAIT_STATES+2 cycles with STB_I held high.
- DAT_O/TGD_O valid only while ACK_O high; 0 in every other cycle.
- All outputs registered; no combinational input-to-output path.

## Configuration
- WB_SLAVE_MEM_RETRY_EN defined: adds input port retry_req (1 bit). If retry_req is high on the edge entering RESP, RTY_O pulses instead of ACK_O/ERR_O, memory untouched, DAT_O/TGD_O=0.
- Undefined: no retry_req port; RTY_O constant 0.

## Test plan
- Reset, WAIT_STATES=1: RST_I high 2 cycles -> all outputs 0; after release with no STB_I, outputs stay 0.
- Write 64'hDEAD_BEEF_0123_4567, TGD 16'hA5A5, SEL 8'hFF to BASE+0x10, then read same, SEL 8'h0F -> write ACK after 2 cycles; read DAT_O=64'h0000_0000_0123_4567, TGD_O=16'hA5A5, single-cycle ACK.
- Partial write SEL 8'h80 data 64'hFF00_... over prior word -> readback 64'hFF00_0000_0123_4567.
- Read at BASE+8·2^ADDR_BITS, and write with SEL_I=0 -> ERR_O one cycle, memory unchanged, DAT_O=0.
- WAIT_STATES=3, drop STB_I after 1 cycle -> no strobe ever, memory unchanged; RST_I during WAIT -> same, outputs 0.
- WB_SLAVE_MEM_RETRY_EN, retry_req=1 on write -> RTY_O pulse, no update; retry with retry_req=0 -> ACK, data written.
